// File: rtl/inst_prefetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch front end.
package inst_prefetch_unit_pkg;

  localparam logic [31:0] INITIAL_PC   = 32'h0040_0000;
  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  // One buffered fetch: the address it came from and the word returned.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential successor of a fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] nextFetchPc(input logic [31:0] pc);
    return pc + FETCH_STRIDE;
  endfunction

endpackage

// File: rtl/inst_prefetch_unit_fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush.
// Used both for fetched instructions and for the addresses of in-flight reads.
module inst_prefetch_unit_fetch_fifo
  import inst_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_pushData,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  // A flush wins over any push or pop in the same cycle.
  assign w_doPush = i_push && !o_full && !i_flush;
  assign w_doPop  = i_pop && !o_empty && !i_flush;

  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

  // Pointer and occupancy bookkeeping; a flush simply rewinds everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_doPush && !w_doPop)
        r_count <= r_count + CNT_ONE;
      else if (!w_doPush && w_doPop)
        r_count <= r_count - CNT_ONE;
    end
  end

  // Storage is cleared on reset so the head reads as zero until first written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: issues sequential reads ahead of the core,
// tracks in-flight requests, and drops responses made stale by a redirect.
module inst_prefetch_unit
  import inst_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = INITIAL_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_available,
  output logic [31:0] inst_address,
  output logic        inst_read_enable,
  input  logic        inst_wait_req,
  input  logic        inst_valid,
  input  logic [31:0] inst_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW:0]   SUM_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetchPc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_accept;
  logic          w_keep;
  logic          w_pop;
  logic [CW:0]   w_inFlight;
  logic [31:0]   w_redirectTarget;

  fetch_entry_t  w_dataIn;
  fetch_entry_t  w_dataHead;
  logic          w_dataFull;
  logic          w_dataEmpty;
  logic [CW-1:0] w_dataCount;

  fetch_entry_t  w_pendIn;
  fetch_entry_t  w_pendHead;
  logic          w_pendFull;
  logic          w_pendEmpty;
  logic [CW-1:0] w_pendCount;
  logic          w_unusedBits;

  // Every slot is a credit: buffered entries plus reads still on the bus.
  assign w_inFlight       = {1'b0, w_dataCount} + {1'b0, r_outstanding};
  assign inst_read_enable = !reset && !redirect && (w_inFlight < SUM_DEPTH);
  assign inst_address     = r_fetchPc;
  assign w_accept         = inst_read_enable && !inst_wait_req;

  // Responses are kept only when not owed to a discard and not racing a redirect.
  assign w_keep = inst_valid && (r_discard == '0) && !redirect;
  assign w_pop  = inst_ready && !w_dataEmpty && !redirect;

  assign w_redirectTarget = {redirect_pc[31:2], 2'b00};

  assign w_dataIn.pc   = w_pendHead.pc;
  assign w_dataIn.inst = inst_data;
  assign w_pendIn.pc   = r_fetchPc;
  assign w_pendIn.inst = '0;

  assign inst           = w_dataHead.inst;
  assign inst_pc        = w_dataHead.pc;
  assign inst_available = !w_dataEmpty;

  // Status of the address queue and low target bits carry no information here.
  assign w_unusedBits = ^{w_pendHead.inst, w_pendFull, w_pendEmpty, w_pendCount,
                          w_dataFull, redirect_pc[1:0]};

  inst_prefetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_dataFifo (
    .clock      (clock),
    .reset      (reset),
    .i_flush    (redirect),
    .i_push     (w_keep),
    .i_pushData (w_dataIn),
    .i_pop      (w_pop),
    .o_head     (w_dataHead),
    .o_full     (w_dataFull),
    .o_empty    (w_dataEmpty),
    .o_count    (w_dataCount)
  );

  inst_prefetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_pendFifo (
    .clock      (clock),
    .reset      (reset),
    .i_flush    (1'b0),
    .i_push     (w_accept),
    .i_pushData (w_pendIn),
    .i_pop      (inst_valid),
    .o_head     (w_pendHead),
    .o_full     (w_pendFull),
    .o_empty    (w_pendEmpty),
    .o_count    (w_pendCount)
  );

  // Fetch address: jumps on redirect, otherwise advances only when the bus takes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_fetchPc <= RESET_PC;
    else if (redirect)
      r_fetchPc <= w_redirectTarget;
    else if (w_accept)
      r_fetchPc <= nextFetchPc(r_fetchPc);
  end

  // Reads on the bus: up on accept, down on response, unchanged when both happen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_outstanding <= '0;
    else if (w_accept && !inst_valid)
      r_outstanding <= r_outstanding + CNT_ONE;
    else if (!w_accept && inst_valid)
      r_outstanding <= r_outstanding - CNT_ONE;
  end

  // On redirect every read still on the bus becomes stale and must be dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_discard <= '0;
    else if (redirect)
      r_discard <= inst_valid ? (r_outstanding - CNT_ONE) : r_outstanding;
    else if (inst_valid && (r_discard != '0))
      r_discard <= r_discard - CNT_ONE;
  end

endmodule
